// File: rtl/ntt_pkg.sv
// Shared definitions for the radix-4 NTT address sequencer: lane count,
// sequencer FSM states and the stage-count helper.
package ntt_pkg;

    localparam int NTT_LANES = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } ntt_state_t;

    function automatic int stage_count(input int logn);
        return logn / 2;
    endfunction

endpackage

// File: rtl/ntt_addr_lane_calc.sv
// Combinational 8-lane read-address bundle for one (p, k, j) point of a
// radix-4 NTT pass. Stage 0 reads eight consecutive words; later stages
// read two interleaved radix-4 butterflies spaced 4^p apart.
module ntt_addr_lane_calc
    import ntt_pkg::*;
#(
    parameter int AW = 10,
    parameter int SW = 3
) (
    input  logic [SW-1:0]           p,
    input  logic [AW-1:0]           k,
    input  logic [AW-1:0]           j,
    output logic [NTT_LANES*AW-1:0] addr
);

    logic [SW:0]   sh;
    logic [SW+1:0] sh2;
    logic [AW-1:0] stride;
    logic [AW-1:0] base;
    logic [AW-1:0] offs [4];

    // Lane addresses from shifts only: 4^p = 1 << 2p, 4^(p+1) = 1 << (2p+2)
    always_comb begin
        sh      = {p, 1'b0};
        sh2     = {1'b0, sh} + (SW+2)'(2);
        stride  = AW'(1) << sh;
        offs[0] = '0;
        offs[1] = stride;
        offs[2] = stride << 1;
        offs[3] = (stride << 1) + stride;
        addr    = '0;
        base    = '0;
        if (p == '0) begin
            base = k << 3;
            for (int i = 0; i < NTT_LANES; i++) begin
                addr[i*AW +: AW] = base + AW'(i);
            end
        end else begin
            base = (k << sh2) + j;
            for (int m = 0; m < 4; m++) begin
                addr[m*AW +: AW]     = base + offs[m];
                addr[(m+4)*AW +: AW] = base + offs[m] + AW'(1);
            end
        end
    end

endmodule

// File: rtl/ntt_addr_seq.sv
// Radix-4 NTT read-address sequencer. Walks every stage/k/j of a 2^LOGN
// transform and emits one 8-lane address bundle per valid/ready beat.
// Optional macro NTT_ADDR_SKID_EN: adds a staging register and a 2-entry
// skid FIFO so the generator never sees out_ready combinationally.
module ntt_addr_seq
    import ntt_pkg::*;
#(
    parameter  int LOGN = 10,
    localparam int AW   = LOGN,
    localparam int SW   = $clog2(LOGN / 2)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   inv,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SW-1:0]          out_stage,
    output logic [NTT_LANES*AW-1:0] out_addr,
    output logic                   out_last_stage,
    output logic                   out_last,
    output logic                   done
);

    localparam int            P      = stage_count(LOGN);
    localparam int            BW     = NTT_LANES * AW + SW + 2;
    localparam logic [SW-1:0] P_LAST = SW'(P - 1);
    localparam logic [AW:0]   N_FULL = {1'b1, {AW{1'b0}}};

    ntt_state_t state, state_nxt;
    logic       start_ok;
    logic       busy_q, done_q;

    logic [SW-1:0] p_q;
    logic [AW-1:0] k_q, j_q;
    logic          inv_q, gen_active_q;

    logic [NTT_LANES*AW-1:0] calc_addr;
    logic [SW:0]             sh;
    logic [SW+1:0]           sh2;
    logic [AW:0]             k_span;
    logic [AW-1:0]           k_last, j_last;
    logic                    stage_end, pass_end;
    logic [BW-1:0]           gen_bundle, out_bundle;
    logic                    gen_fire, pop, valid_w;

    ntt_addr_lane_calc #(.AW(AW), .SW(SW)) u_lane_calc (
        .p    (p_q),
        .k    (k_q),
        .j    (j_q),
        .addr (calc_addr)
    );

    // Terminal-count detection for the bundle currently being generated
    always_comb begin
        sh         = {p_q, 1'b0};
        sh2        = {1'b0, sh} + (SW+2)'(2);
        k_span     = (p_q == '0) ? (N_FULL >> 3) : (N_FULL >> sh2);
        k_last     = AW'(k_span - (AW+1)'(1));
        j_last     = (AW'(1) << sh) - AW'(2);
        stage_end  = (k_q == k_last) && ((p_q == '0) || (j_q == j_last));
        pass_end   = stage_end && (p_q == (inv_q ? SW'(0) : P_LAST));
        gen_bundle = {pass_end, stage_end, p_q, calc_addr};
    end

    // Next-state logic; start is only honoured from IDLE
    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_nxt = RUN;
                start_ok  = 1'b1;
            end
            RUN:  if (pop && out_bundle[BW-1]) state_nxt = FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register plus registered busy/done decodes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt == RUN);
            done_q <= (state_nxt == FIN);
        end
    end

    // Stage/k/j walk; j runs fastest, everything wraps at a stage change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q          <= '0;
            k_q          <= '0;
            j_q          <= '0;
            inv_q        <= 1'b0;
            gen_active_q <= 1'b0;
        end else if (start_ok) begin
            inv_q        <= inv;
            p_q          <= inv ? P_LAST : '0;
            k_q          <= '0;
            j_q          <= '0;
            gen_active_q <= 1'b1;
        end else if (gen_fire) begin
            if (pass_end) begin
                gen_active_q <= 1'b0;
            end else if (stage_end) begin
                p_q <= inv_q ? p_q - SW'(1) : p_q + SW'(1);
                k_q <= '0;
                j_q <= '0;
            end else if ((p_q == '0) || (j_q == j_last)) begin
                k_q <= k_q + AW'(1);
                j_q <= '0;
            end else begin
                j_q <= j_q + AW'(2);
            end
        end
    end

`ifdef NTT_ADDR_SKID_EN
    logic          s_valid_q;
    logic [BW-1:0] s_bundle_q, head_q, tail_q;
    logic [1:0]    cnt_q;
    logic          push;

    // Generator only looks at registered occupancy, never at out_ready
    assign push     = s_valid_q && (cnt_q != 2'd2);
    assign gen_fire = gen_active_q && (!s_valid_q || push);
    assign pop      = (cnt_q != 2'd0) && out_ready;
    assign valid_w  = (cnt_q != 2'd0);

    // Staging register between the generator and the skid FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid_q  <= 1'b0;
            s_bundle_q <= '0;
        end else if (gen_fire) begin
            s_valid_q  <= 1'b1;
            s_bundle_q <= gen_bundle;
        end else if (push) begin
            s_valid_q  <= 1'b0;
        end
    end

    // Two-entry skid FIFO; head_q drives the outputs directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
            case (cnt_q)
                2'd0: if (push) head_q <= s_bundle_q;
                2'd1: begin
                    if (push && pop) head_q <= s_bundle_q;
                    else if (push)   tail_q <= s_bundle_q;
                end
                2'd2: if (pop) head_q <= tail_q;
                default: ;
            endcase
        end
    end

    assign out_bundle = head_q;
`else
    logic          valid_q;
    logic [BW-1:0] bundle_q;

    assign gen_fire = gen_active_q && (!valid_q || out_ready);
    assign pop      = valid_q && out_ready;
    assign valid_w  = valid_q;

    // Single output register; contents persist after the final transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else if (gen_fire) begin
            valid_q  <= 1'b1;
            bundle_q <= gen_bundle;
        end else if (pop) begin
            valid_q  <= 1'b0;
        end
    end

    assign out_bundle = bundle_q;
`endif

    assign out_valid = valid_w;
    assign {out_last, out_last_stage, out_stage, out_addr} = out_bundle;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_ntt_addr_seq.sv
// Self-checking bench for ntt_addr_seq at LOGN=10 with randomized backpressure.
module tb_ntt_addr_seq;

    localparam int LOGN  = 10;
    localparam int AW    = 10;
    localparam int SW    = 3;
    localparam int N     = 1024;
    localparam int P     = 5;
    localparam int BEATS = 640;
    localparam int BW    = 8 * AW + SW + 2;
`ifdef NTT_ADDR_SKID_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst, start, inv, out_ready;
    logic          busy, out_valid, out_last_stage, out_last, done;
    logic [SW-1:0] out_stage;
    logic [8*AW-1:0] out_addr;

    int n_cmp = 0;
    int n_bad = 0;
    logic [BW-1:0] exp_q[$];

    ntt_addr_seq #(.LOGN(LOGN)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .inv            (inv),
        .busy           (busy),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_stage      (out_stage),
        .out_addr       (out_addr),
        .out_last_stage (out_last_stage),
        .out_last       (out_last),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Expected beat sequence straight from the stage/group/offset definition
    function automatic void build_model(input bit inv_i);
        logic [8*AW-1:0] a;
        logic [BW-1:0]   b;
        exp_q.delete();
        for (int s = 0; s < P; s++) begin
            int p;
            int q;
            int idx;
            p   = inv_i ? (P - 1 - s) : s;
            q   = 4 ** p;
            idx = 0;
            if (p == 0) begin
                for (int k = 0; k < N / 8; k++) begin
                    for (int i = 0; i < 8; i++) a[i*AW +: AW] = AW'(8 * k + i);
                    b = {1'b0, (idx == N / 8 - 1), SW'(p), a};
                    exp_q.push_back(b);
                    idx++;
                end
            end else begin
                for (int k = 0; k < N / (4 * q); k++) begin
                    for (int j = 0; j < q; j += 2) begin
                        int base;
                        base = k * 4 * q + j;
                        for (int m = 0; m < 4; m++) begin
                            a[m*AW +: AW]     = AW'(base + m * q);
                            a[(m+4)*AW +: AW] = AW'(base + 1 + m * q);
                        end
                        b = {1'b0, (idx == N / 8 - 1), SW'(p), a};
                        exp_q.push_back(b);
                        idx++;
                    end
                end
            end
        end
        b = exp_q.pop_back();
        b[BW-1] = 1'b1;
        exp_q.push_back(b);
    endfunction

    // mode 0: ready always high, 1: random ready, 2: 3-cycle stall in stage 2
    task automatic run_pass(input bit inv_i, input int mode, input int rst_beat, input bit poke_start);
        int beat = 0;
        int cyc = 0;
        int lat = 0;
        int bubbles = 0;
        int early_done = 0;
        int stall_left = 0;
        bit stalled_once = 0;
        bit prev_stall = 0;
        bit finished = 0;
        logic [BW-1:0] obs;
        logic [BW-1:0] last_exp;

        build_model(inv_i);
        last_exp = exp_q[BEATS-1];

        inv   = inv_i;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        inv   = 1'($urandom);
        chk("busy_after_start", busy, 1);
        chk("valid_after_start", out_valid, 0);
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("first_latency", lat, LAT);

        while (!finished && cyc < 5000) begin
            if (prev_stall) chk("hold_valid", out_valid, 1);
            if (out_valid) begin
                obs = {out_last, out_last_stage, out_stage, out_addr};
                if (beat < BEATS) begin
                    chk($sformatf("beat%0d", beat), obs, exp_q[beat]);
                end else begin
                    chk("beat_overrun", beat, BEATS);
                    finished = 1;
                end
            end else if (beat > 0) begin
                bubbles++;
            end
            if (done) early_done++;

            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (beat == 306 && !stalled_once) begin
                        stall_left   = 3;
                        stalled_once = 1;
                    end
                    out_ready = (stall_left == 0);
                    if (stall_left > 0) stall_left--;
                end
            endcase
            if (poke_start && beat == 200) begin
                start = 1'b1;
                inv   = ~inv_i;
            end else begin
                start = 1'b0;
            end

            prev_stall = out_valid && !out_ready;
            if (out_valid && out_ready) begin
                beat++;
                if (out_last) finished = 1;
            end

            if (rst_beat >= 0 && beat == rst_beat) begin
                @(posedge clk); #3;
                rst = 1'b1;
                #1;
                chk("rst_valid", out_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_addr", out_addr, 0);
                chk("rst_stage", out_stage, 0);
                chk("rst_last_stage", out_last_stage, 0);
                chk("rst_last", out_last, 0);
                chk("rst_done", done, 0);
                chk("rst_early_done", early_done, 0);
                repeat (2) @(posedge clk);
                #1;
                rst   = 1'b0;
                start = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(posedge clk); #1;
                    chk("post_rst_done", done, 0);
                    chk("post_rst_valid", out_valid, 0);
                end
                return;
            end

            @(posedge clk); #1;
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b1;

        chk("pass_finished", finished, 1);
        chk("beat_count", beat, BEATS);
        chk("early_done", early_done, 0);
        chk("bubbles", bubbles, 0);
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
        chk("valid_at_done", out_valid, 0);
        chk("addr_kept", out_addr, last_exp[8*AW-1:0]);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        inv       = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_stage", out_stage, 0);
        chk("reset_addr", out_addr, 0);
        chk("reset_last_stage", out_last_stage, 0);
        chk("reset_last", out_last, 0);
        chk("reset_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_pass(1'b0, 0, -1, 1'b0);
        run_pass(1'b1, 0, -1, 1'b0);
        run_pass(1'b0, 2, -1, 1'b1);
        run_pass(1'b1, 1, -1, 1'b0);
        run_pass(1'b0, 0, 300, 1'b0);
        run_pass(1'b0, 1, -1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ntt_addr_seq.md
Name: ntt_addr_seq

Overview:
- Sequential radix-4 NTT read-address sequencer for the 4x2-BFU datapath.
- Walks every stage, group (k) and offset (j) of a length-2^LOGN transform by itself. Emits one 8-lane address bundle per valid/ready beat.
- Adds parametrised transform size, forward/inverse stage ordering, backpressure and start/done control.
- Sits between the NTT controller and the memory-bank read ports.

Parameters:
- LOGN, 10, log2 of transform length N. Even; legal range 4..14. Address width AW = LOGN.
- SW, derived $clog2(LOGN/2), width of the stage index. Localparam, not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request to begin a full pass; honoured only when idle
- inv  in  1  stage order, sampled with start: 0 = ascending p, 1 = descending p
- busy  out  1  high from accepted start until the final beat handshakes
- out_valid  out  1  address bundle valid
- out_ready  in  1  consumer accepts the bundle
- out_stage  out  SW  stage p of the current bundle
- out_addr  out  8*AW  lane m occupies bits [m*AW +: AW]; lane 0 is in the LSBs
- out_last_stage  out  1  last beat of the current stage
- out_last  out  1  last beat of the whole pass
- done  out  1  one-cycle pulse after the final handshake

Behaviour:
- Reset values: busy=0, out_valid=0, out_stage=0, out_addr=0, out_last_stage=0, out_last=0, done=0. All counters are 0 and the FSM is in IDLE.
- FSM states:
  - IDLE: start → RUN.
  - RUN: handshake with out_last=1 → FIN.
  - FIN: one cycle, done=1 → IDLE.
- A start seen in RUN or FIN is ignored.
- Stage count P = LOGN/2, so p ranges 0..P-1.
  - inv=0: stages visited 0,1,...,P-1.
  - inv=1: stages visited P-1,...,0.
- Stage p=0: counter k runs 0..N/8-1. Lane i address = 8k + i.
- Stage p>0:
  - Outer k runs 0..N/4^(p+1)-1.
  - Inner j runs 0,2,4,...,4^p-2; j increments fastest.
  - base = k·4^(p+1) + j.
  - Lane m (m=0..3) = base + m·4^p.
  - Lane 4+m = base + 1 + m·4^p.
- Every stage takes exactly N/8 beats; a pass takes P·N/8 beats (640 at LOGN=10).
- Latency: start accepted at edge t → out_valid=1 with the first bundle after edge t+1. All outputs are registered.
- Handshake:
  - A beat transfers on the clock edge where out_valid && out_ready.
  - While out_valid && !out_ready, every out_* signal holds stable.
  - out_valid never drops without a transfer.
  - Back-to-back beats run at full rate while out_ready=1.
- Stage transitions:
  - After the beat with out_last_stage=1, the next bundle carries the next stage, with no bubble.
  - k and j wrap to 0 at each stage change.
- After the final transfer: out_valid=0 and busy=0 in the same cycle that done=1. out_addr keeps its last value.
- Reset mid-operation (rst asserted in any state): immediate return to IDLE with all reset values. No done pulse.
- Arithmetic: all computed in AW bits; by construction no result overflows N-1. Multiplication by 4^p is implemented as a shift by 2p; no multipliers.

Optional Feature:
- Macro NTT_ADDR_SKID_EN.
- Defined: a 2-entry skid buffer sits on the output. The internal advance uses a registered ready, so there is no combinational path from out_ready back to the counters. First-bundle latency becomes t+2; throughput is still one beat per cycle; hold/stability rules are unchanged.
- Undefined: single output register, latency as stated above.

Decomposition:
- Shared package ntt_pkg holds:
  - the lane count constant NTT_LANES=8;
  - the FSM state typedef (IDLE/RUN/FIN);
  - a function stage_count(LOGN) returning LOGN/2.
- One natural sub-module, ntt_addr_lane_calc: a purely combinational bundle computation from (p, k, j) to 8 addresses. The parent owns the FSM, counters, output register and skid buffer.

Test Plan:
- LOGN=10, inv=0, out_ready=1 → first bundle 0..7; second bundle 8..15; beat 128 is 1016..1023 with out_last_stage=1 and out_stage=0.
- Same run, stage 1 → first bundles 0,4,8,12,1,5,9,13 then 2,6,10,14,3,7,11,15 then 16,20,24,28,17,21,25,29.
- Same run, stage 4 → first bundle 0,256,512,768,1,257,513,769. Final bundle 254,510,766,1022,255,511,767,1023 with out_last=1. done pulses next cycle; total 640 beats.
- inv=1 → first bundle at out_stage=4 is 0,256,512,768,...; final bundle is out_stage=0, 1016..1023.
- out_ready held low 3 cycles mid-stage-2 → all outputs frozen; no beat skipped or duplicated; count still 640. A start pulse while busy has no effect.
- rst pulsed at beat 300 → all outputs 0 asynchronously, no done pulse. A new start restarts from stage 0, bundle 0..7.
